beat_clock_generator: RTL and testbench
=======================================

// Module: beat_clock_generator
// PURPOSE
// - Tempo/transport stage that drives the step index into audio_controller; replaces the free-running seconds counter in top.
// - Generates the sequencer step index beat_count and a one-cycle step_tick at a rotary-controlled tempo.
// - Handles play/pause/stop transport and BPM changes.
// - Recomputes the step period with a sequential divider, so no combinational divide sits on the clock path.
// PARAMETERS
// - CLK_FREQ        12_000_000  system clock in Hz
// - NUM_BEATS       16          steps per bar (power of two)
// - STEPS_PER_BEAT  4           steps per quarter note (16ths)
// - BPM_MIN         60          lower tempo saturation limit
// - BPM_MAX         240         upper tempo saturation limit
// - BPM_DEFAULT     120         tempo after reset
// - BPM_STEP        4           BPM change per tempo_up/tempo_down pulse
// - DIV_W           32          divider/period width; must hold CLK_FREQ*60
// PORTS
// - clk          in   1                   system clock
// - rst_n        in   1                   synchronous reset, active-low
// - play_toggle  in   1                   1-cycle pulse: STOPPED/PAUSED->PLAYING, PLAYING->PAUSED
// - stop         in   1                   1-cycle pulse: ->STOPPED, step index cleared
// - tempo_up     in   1                   1-cycle pulse: bpm += BPM_STEP
// - tempo_down   in   1                   1-cycle pulse: bpm -= BPM_STEP
// - beat_count   out  $clog2(NUM_BEATS)   current step index
// - step_tick    out  1                   1-cycle pulse when a step starts
// - bar_start    out  1                   step_tick && beat_count==0
// - playing      out  1                   state==PLAYING
// - bpm          out  8                   current tempo
// BEHAVIOUR
// - Reset values:
//   - beat_count=0, step_tick=0, bar_start=0, playing=0, bpm=BPM_DEFAULT
//   - phase=0; period=DEFAULT_PERIOD (elaboration constant); divider idle, no pending request
// - Step period: period = floor(CLK_FREQ*60 / (bpm*STEPS_PER_BEAT)) clock cycles.
// - States: STOPPED, PLAYING, PAUSED.
//   - STOPPED --play_toggle--> PLAYING. On entry: beat_count=0, phase=0, step_tick=bar_start=1 in the first PLAYING cycle.
//   - PLAYING --play_toggle--> PAUSED. beat_count and phase are frozen; no ticks.
//   - PAUSED --play_toggle--> PLAYING. Resumes from the frozen phase; no immediate tick.
//   - Any state --stop--> STOPPED. beat_count=0, phase=0. stop wins over a simultaneous play_toggle.
// - PLAYING counting:
//   - phase increments every cycle.
//   - When phase >= period-1: phase<=0, beat_count<=beat_count+1 (wraps mod NUM_BEATS), step_tick pulses in the cycle after the wrap.
//   - Using >= means a shortened period takes effect without overshoot.
// - Tempo:
//   - tempo_up/tempo_down take effect in any state.
//   - bpm saturates at BPM_MIN/BPM_MAX; at a limit, the pulse is ignored and no divide is started.
//   - tempo_up and tempo_down in the same cycle: both ignored.
// - Divider launch:
//   - A bpm change launches period_divider, latency DIV_W+1 cycles, start to done.
//   - A change while the divider is busy sets a pending flag; on done, one relaunch with the latest bpm.
//   - Intermediate results are still loaded.
// - New period is loaded into the period register on the divider done cycle.
//   - The current step completes against the new value.
//   - The old period stays in effect while the divider is busy.
// - Reset mid-divide aborts the divide; the period returns to DEFAULT_PERIOD.
// CONFIGURATION
// - SWING_EN defined:
//   - Odd steps (beat_count[0]==1) last period + (period>>3).
//   - Even steps last period - (period>>3).
//   - Bar length is unchanged within ±1 cycle per step pair.
// - SWING_EN undefined: every step lasts exactly period cycles; no swing logic is synthesised.
// STRUCTURE
// - sequencer_pkg:
//   - typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} transport_t
//   - localparams CLK_FREQ, NUM_BEATS, BEAT_W=$clog2(NUM_BEATS)
//   - shared with model and audio_controller
// - Sub-module period_divider:
//   - restoring shift-subtract divider, DIV_W-bit numerator and denominator
//   - ports: start/busy/done/quotient
// - Top-level wiring:
//   - tempo_up/tempo_down come from rotary_encoder direction pulses
//   - play_toggle comes from the rotary_encoder button
// TESTING (CLK_FREQ=1200, STEPS_PER_BEAT=4 -> period 150 at 120 BPM)
// 1. Reset then play_toggle -> step_tick and bar_start in the next cycle; ticks every 150 cycles; beat_count 0..15 then back to 0 with bar_start.
// 2. tempo_up once -> bpm=124, done after 33 cycles, period=145; next step interval is 145 cycles.
// 3. 50 tempo_up pulses -> bpm holds 240, period=75; tempo_up and tempo_down together -> bpm unchanged.
// 4. Pause at beat_count=5 mid-step, wait 1000 cycles, resume -> no tick until the remaining phase elapses; next beat_count=6.
// 5. stop together with play_toggle while PLAYING -> STOPPED, beat_count=0, playing=0; rst_n low mid-divide -> bpm=120, period=150.
// 6. SWING_EN, 120 BPM -> step intervals alternate 132 and 168 cycles (even step short, odd step long).

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared sequencer types and constants for the tempo/transport stage,
// its bench model and audio_controller.
package sequencer_pkg;

   typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} transport_t;

   localparam int CLK_FREQ  = 12_000_000;
   localparam int NUM_BEATS = 16;
   localparam int BEAT_W    = $clog2(NUM_BEATS);

endpackage

// File: rtl/period_divider.sv
// Restoring shift-subtract divider; done arrives DIV_W+1 cycles after start.
// start is ignored while busy; quotient holds its value until the next start.
module period_divider #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] numer,
   input  logic [DIV_W-1:0] denom,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient
);

   localparam int CW = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] rem;
   logic [DIV_W-1:0] den;
   logic [CW-1:0]    cnt;
   logic [DIV_W:0]   trial;

   // quotient doubles as the numerator shift register
   assign trial = {rem, quotient[DIV_W-1]};
   assign done  = busy && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         den      <= '0;
         quotient <= '0;
      end else if (start && !busy) begin
         busy     <= 1'b1;
         cnt      <= CW'(DIV_W);
         rem      <= '0;
         den      <= denom;
         quotient <= numer;
      end else if (busy) begin
         if (cnt == '0) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt - CW'(1);
            if (trial >= {1'b0, den}) begin
               rem      <= DIV_W'(trial - {1'b0, den});
               quotient <= {quotient[DIV_W-2:0], 1'b1};
            end else begin
               rem      <= trial[DIV_W-1:0];
               quotient <= {quotient[DIV_W-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/beat_clock_generator.sv
// Tempo/transport stage: step index, step tick and bar start at a rotary-set BPM.
// Define SWING_EN to lengthen odd steps and shorten even steps by period>>3.
module beat_clock_generator #(
   parameter int CLK_FREQ       = 12_000_000,
   parameter int NUM_BEATS      = 16,
   parameter int STEPS_PER_BEAT = 4,
   parameter int BPM_MIN        = 60,
   parameter int BPM_MAX        = 240,
   parameter int BPM_DEFAULT    = 120,
   parameter int BPM_STEP       = 4,
   parameter int DIV_W          = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         play_toggle,
   input  logic                         stop,
   input  logic                         tempo_up,
   input  logic                         tempo_down,
   output logic [$clog2(NUM_BEATS)-1:0] beat_count,
   output logic                         step_tick,
   output logic                         bar_start,
   output logic                         playing,
   output logic [7:0]                   bpm
);

   import sequencer_pkg::*;

   localparam int CNT_W = $clog2(NUM_BEATS);
   localparam logic [DIV_W-1:0] NUMER = DIV_W'(CLK_FREQ * 60);
   localparam logic [DIV_W-1:0] DEFAULT_PERIOD =
      DIV_W'((CLK_FREQ * 60) / (BPM_DEFAULT * STEPS_PER_BEAT));

   transport_t       state, state_nxt;
   logic             enter_play, count_en;
   logic [DIV_W-1:0] phase, period, step_len, quotient, denom;
   logic [8:0]       bpm_nxt;
   logic             bpm_chg, pending;
   logic             div_start, div_busy, div_done;

   always_comb begin
      state_nxt  = state;
      enter_play = 1'b0;
      count_en   = 1'b0;
      if (stop) begin
         state_nxt = STOPPED;
      end else if (play_toggle) begin
         case (state)
            STOPPED: begin
               state_nxt  = PLAYING;
               enter_play = 1'b1;
            end
            PLAYING: state_nxt = PAUSED;
            default: state_nxt = PLAYING;
         endcase
      end else begin
         count_en = (state == PLAYING);
      end
   end

`ifdef SWING_EN
   logic [DIV_W-1:0] swing;
   assign swing    = period >> 3;
   assign step_len = beat_count[0] ? period + swing : period - swing;
`else
   assign step_len = period;
`endif

   // >= so a freshly shortened period ends the current step without overshoot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= STOPPED;
         beat_count <= '0;
         phase      <= '0;
         step_tick  <= 1'b0;
      end else begin
         state     <= state_nxt;
         step_tick <= 1'b0;
         if (stop) begin
            beat_count <= '0;
            phase      <= '0;
         end else if (enter_play) begin
            beat_count <= '0;
            phase      <= '0;
            step_tick  <= 1'b1;
         end else if (count_en) begin
            if (phase >= step_len - DIV_W'(1)) begin
               phase      <= '0;
               beat_count <= beat_count + CNT_W'(1);
               step_tick  <= 1'b1;
            end else begin
               phase <= phase + DIV_W'(1);
            end
         end
      end
   end

   assign bar_start = step_tick && (beat_count == '0);
   assign playing   = (state == PLAYING);

   always_comb begin
      bpm_nxt = {1'b0, bpm};
      bpm_chg = 1'b0;
      if (tempo_up && !tempo_down && (bpm < 8'(BPM_MAX))) begin
         bpm_chg = 1'b1;
         bpm_nxt = ({1'b0, bpm} + 9'(BPM_STEP) > 9'(BPM_MAX)) ?
                   9'(BPM_MAX) : {1'b0, bpm} + 9'(BPM_STEP);
      end else if (tempo_down && !tempo_up && (bpm > 8'(BPM_MIN))) begin
         bpm_chg = 1'b1;
         bpm_nxt = ({1'b0, bpm} < 9'(BPM_MIN + BPM_STEP)) ?
                   9'(BPM_MIN) : {1'b0, bpm} - 9'(BPM_STEP);
      end
   end

   // the divider always sees the newest bpm, including one changing this cycle
   assign div_start = (bpm_chg || pending) && !div_busy;
   assign denom     = DIV_W'(bpm_nxt) * DIV_W'(STEPS_PER_BEAT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bpm     <= 8'(BPM_DEFAULT);
         pending <= 1'b0;
         period  <= DEFAULT_PERIOD;
      end else begin
         bpm <= bpm_nxt[7:0];
         if (div_start)    pending <= 1'b0;
         else if (bpm_chg) pending <= 1'b1;
         if (div_done)     period  <= quotient;
      end
   end

   period_divider #(.DIV_W(DIV_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .numer    (NUMER),
      .denom    (denom),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

endmodule

// File: tb/tb_beat_clock_generator.sv
// Randomised/directed bench for beat_clock_generator at CLK_FREQ=1200 (period 150 @120 BPM).
// A tempo/transport model predicts every cycle's outputs into a scoreboard queue.
module tb_beat_clock_generator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       play_toggle = 1'b0, stop = 1'b0, tempo_up = 1'b0, tempo_down = 1'b0;
   logic [3:0] beat_count;
   logic       step_tick, bar_start, playing;
   logic [7:0] bpm;

   beat_clock_generator #(.CLK_FREQ(1200)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .play_toggle (play_toggle),
      .stop        (stop),
      .tempo_up    (tempo_up),
      .tempo_down  (tempo_down),
      .beat_count  (beat_count),
      .step_tick   (step_tick),
      .bar_start   (bar_start),
      .playing     (playing),
      .bpm         (bpm)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      int beat;
      bit tick;
      bit bar;
      bit play;
      int bpm;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0, errors = 0;

   // model: transport 0=stopped 1=playing 2=paused; elapsed = cycles spent in current step
   int m_st, m_beat, m_elapsed, m_bpm, m_period, m_div_at, m_div_bpm, cyc_n;
   bit m_pend, m_tick;

   function automatic int step_cycles(int per, int beat);
`ifdef SWING_EN
      return (beat % 2 == 1) ? per + per / 8 : per - per / 8;
`else
      return per;
`endif
   endfunction

   task automatic model_step(input bit r, input bit pt, input bit sp, input bit up, input bit dn);
      int  nb;
      bit  chg, div_running;
      exp_t e;
      m_tick = 1'b0;
      if (!r) begin
         m_st = 0; m_beat = 0; m_elapsed = 0; m_bpm = 120; m_period = 150;
         m_div_at = -1000; m_pend = 1'b0;
      end else begin
         if (sp) begin
            m_st = 0; m_beat = 0; m_elapsed = 0;
         end else if (pt) begin
            if (m_st == 0) begin
               m_st = 1; m_beat = 0; m_elapsed = 0; m_tick = 1'b1;
            end else m_st = (m_st == 1) ? 2 : 1;
         end else if (m_st == 1) begin
            m_elapsed++;
            if (m_elapsed >= step_cycles(m_period, m_beat)) begin
               m_elapsed = 0; m_beat = (m_beat + 1) % 16; m_tick = 1'b1;
            end
         end
         // a divide launched at cycle L reports at cycle L+33
         div_running = (cyc_n > m_div_at) && (cyc_n <= m_div_at + 33);
         if (div_running && cyc_n == m_div_at + 33) m_period = 72000 / (m_div_bpm * 4);
         nb = m_bpm; chg = 1'b0;
         if (up && !dn && m_bpm < 240) begin
            nb = (m_bpm + 4 > 240) ? 240 : m_bpm + 4; chg = 1'b1;
         end else if (dn && !up && m_bpm > 60) begin
            nb = (m_bpm - 4 < 60) ? 60 : m_bpm - 4; chg = 1'b1;
         end
         if ((chg || m_pend) && !div_running) begin
            m_div_at = cyc_n; m_div_bpm = nb; m_pend = 1'b0;
         end else if (chg) m_pend = 1'b1;
         m_bpm = nb;
      end
      e.n = cyc_n; e.beat = m_beat; e.tick = m_tick; e.bar = m_tick && (m_beat == 0);
      e.play = (m_st == 1); e.bpm = m_bpm;
      sbq.push_back(e);
      cyc_n++;
   endtask

   task automatic cyc(input bit r = 1, input bit pt = 0, input bit sp = 0,
                      input bit up = 0, input bit dn = 0);
      @(negedge clk);
      rst_n = r; play_toggle = pt; stop = sp; tempo_up = up; tempo_down = dn;
      model_step(r, pt, sp, up, dn);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // monitor: one expected record per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (beat_count !== 4'(e.beat) || step_tick !== e.tick || bar_start !== e.bar ||
                playing !== e.play || bpm !== 8'(e.bpm)) begin
               errors++;
               $display("FAIL cycle %0d: got beat=%0d tick=%b bar=%b play=%b bpm=%0d, want beat=%0d tick=%b bar=%b play=%b bpm=%0d",
                        e.n, beat_count, step_tick, bar_start, playing, bpm,
                        e.beat, e.tick, e.bar, e.play, e.bpm);
            end
         end
      end
   end

   initial begin
      int guard;
      cyc_n = 0;
      cyc(0); cyc(0); cyc(0);
      idle(5);
      // full bar at 150 cycles/step and wrap back to step 0
      cyc(1, 1);
      idle(16 * 150 + 40);
      // single tempo step, then many with overlapping divides up to saturation
      cyc(1, 0, 0, 1);
      idle(400);
      for (int i = 0; i < 50; i++) begin
         cyc(1, 0, 0, 1);
         idle(4);
      end
      idle(200);
      cyc(1, 0, 0, 1, 1);
      idle(300);
      for (int i = 0; i < 30; i++) begin
         cyc(1, 0, 0, 0, 1);
         idle(2);
      end
      idle(200);
      // pause mid-step on step 5, hold, resume
      guard = 0;
      while (!(m_st == 1 && m_beat == 5 && m_elapsed == 60) && guard < 5000) begin
         cyc();
         guard++;
      end
      if (guard >= 5000) begin
         checks++; errors++;
         $display("FAIL pause_point: never reached step 5, got beat=%0d want 5", m_beat);
      end
      cyc(1, 1);
      idle(1000);
      cyc(1, 1);
      idle(500);
      // stop beats a simultaneous play_toggle
      cyc(1, 1, 1);
      idle(20);
      // reset in the middle of a divide
      cyc(1, 1);
      cyc(1, 0, 0, 1);
      idle(10);
      cyc(0); cyc(0);
      cyc(1, 1);
      idle(400);
      // random transport and tempo traffic
      for (int i = 0; i < 6000; i++) begin
         automatic bit r  = ($urandom_range(0, 2999) != 0);
         automatic bit pt = ($urandom_range(0, 299) == 0);
         automatic bit sp = ($urandom_range(0, 999) == 0);
         automatic bit up = ($urandom_range(0, 99) < 2);
         automatic bit dn = ($urandom_range(0, 99) < 2);
         if (m_st == 0 && $urandom_range(0, 19) == 0) pt = 1'b1;
         cyc(r, pt, sp, up, dn);
      end
      idle(5);
      @(posedge clk);
      #3;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
